multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_pkg.sv | 59 +++++
 rtl/mc_instret_counter.sv | 21 ++
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// major opcodes and the datapath mux/control select values.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXR    = 4'd6,
    S_EXI    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JAL  = 2'b10;
  localparam logic [1:0] BR_JALR = 2'b11;

endpackage

// File: rtl/mc_instret_counter.sv
// Retired-instruction counter; wraps modulo 2**CNT_W, cleared by async reset.
module mc_instret_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: state register plus combinational output decode,
// and a retired-instruction counter bumped on every non-trap return to fetch.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       op_i,
  input  logic             memAck_i,
  output logic             memReq_o,
  output logic             memWrite_o,
  output logic             adrSrc_o,
  output logic             irWrite_o,
  output logic             pcWrite_o,
  output logic [1:0]       branch_o,
  output logic [1:0]       aluSrcA_o,
  output logic [1:0]       aluSrcB_o,
  output logic [1:0]       aluOp_o,
  output logic [2:0]       immSrc_o,
  output logic [1:0]       resultSrc_o,
  output logic             regWrite_o,
  output logic             illegal_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instret_o
);

  state_t state;
  state_t next_state;
  logic   trap_q;
  logic   retire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_FETCH;
      trap_q <= 1'b0;
    end else begin
      state  <= next_state;
      trap_q <= (state == S_TRAP);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (memAck_i) next_state = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXR;
          OP_ITYPE:          next_state = S_EXI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: next_state = op_i[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (memAck_i) next_state = S_MEMWB;
      S_MEMWR:  if (memAck_i) next_state = S_FETCH;
      S_EXR,
      S_EXI:    next_state = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_LUI:    next_state = S_FETCH;
      S_TRAP:   if (!TRAP_HALT) next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    memReq_o    = 1'b0;
    memWrite_o  = 1'b0;
    adrSrc_o    = 1'b0;
    irWrite_o   = 1'b0;
    pcWrite_o   = 1'b0;
    branch_o    = BR_NONE;
    aluSrcA_o   = SRCA_PC;
    aluSrcB_o   = SRCB_RS2;
    aluOp_o     = ALU_ADD;
    immSrc_o    = IMM_I;
    resultSrc_o = RES_ALU;
    regWrite_o  = 1'b0;
    illegal_o   = 1'b0;
    halted_o    = 1'b0;
    case (state)
      S_FETCH: begin
        memReq_o = 1'b1;
        // The IR/PC strobes only fire on the acknowledged cycle; reset keeps them quiet.
        if (memAck_i && !rst_i) begin
          irWrite_o = 1'b1;
          pcWrite_o = 1'b1;
          aluSrcA_o = SRCA_PC;
          aluSrcB_o = SRCB_FOUR;
          aluOp_o   = ALU_ADD;
        end
      end
      S_DECODE: begin
        aluSrcA_o = SRCA_OLDPC;
        aluSrcB_o = SRCB_IMM;
        immSrc_o  = IMM_B;
        aluOp_o   = ALU_ADD;
      end
      S_MEMADR: begin
        aluSrcA_o = SRCA_RS1;
        aluSrcB_o = SRCB_IMM;
        aluOp_o   = ALU_ADD;
        immSrc_o  = op_i[5] ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        memReq_o = 1'b1;
        adrSrc_o = 1'b1;
      end
      S_MEMWB: begin
        regWrite_o  = 1'b1;
        resultSrc_o = RES_MEM;
      end
      S_MEMWR: begin
        memReq_o   = 1'b1;
        memWrite_o = 1'b1;
        adrSrc_o   = 1'b1;
      end
      S_EXR: begin
        aluSrcA_o = SRCA_RS1;
        aluSrcB_o = SRCB_RS2;
        aluOp_o   = ALU_FUNCT;
      end
      S_EXI: begin
        aluSrcA_o = SRCA_RS1;
        aluSrcB_o = SRCB_IMM;
        immSrc_o  = IMM_I;
        aluOp_o   = ALU_FUNCT;
      end
      S_ALUWB: begin
        regWrite_o  = 1'b1;
        resultSrc_o = RES_ALU;
      end
      S_BRANCH: begin
        branch_o  = BR_COND;
        aluSrcA_o = SRCA_RS1;
        aluSrcB_o = SRCB_RS2;
        aluOp_o   = ALU_SUB;
      end
      S_JAL: begin
        branch_o    = BR_JAL;
        immSrc_o    = IMM_J;
        regWrite_o  = 1'b1;
        resultSrc_o = RES_PC4;
      end
      S_JALR: begin
        branch_o    = BR_JALR;
        aluSrcA_o   = SRCA_RS1;
        aluSrcB_o   = SRCB_IMM;
        immSrc_o    = IMM_I;
        regWrite_o  = 1'b1;
        resultSrc_o = RES_PC4;
      end
      S_LUI: begin
        regWrite_o  = 1'b1;
        resultSrc_o = RES_IMM;
        immSrc_o    = IMM_U;
      end
      S_TRAP: begin
        // trap_q marks cycles after the first, so the pulse is one cycle even when halted.
        illegal_o = !trap_q;
        halted_o  = TRAP_HALT;
      end
      default: begin
        memReq_o = 1'b0;
      end
    endcase
  end

  assign retire = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_TRAP);

  mc_instret_counter #(
    .CNT_W(CNT_W)
  ) u_instret (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (retire),
    .count (instret_o)
  );

endmodule
